// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four valid/ready requesters share one 4:1 data mux feeding
// a registered valid/ready output stage.
// Macro MUX4_RR_ARBITER_ROUND_ROBIN_EN: when defined, arbitration is round-robin
// starting from a rotating pointer; when undefined, fixed priority (0 highest).
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 2;

    logic             can_load;
    logic             found;
    logic             load;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] base;
    logic [WIDTH-1:0] mux_data;

    // Output register may take a new item when empty or being drained this edge
    assign can_load = !out_valid || out_ready;
    assign load     = can_load && found;

`ifdef MUX4_RR_ARBITER_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr;

    // Rotating priority pointer: one past the last winner, moves only on a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= SEL_W'(winner + SEL_W'(1));
        end
    end

    assign base = ptr;
`else
    // Fixed priority: search always starts at requester 0
    assign base = '0;
`endif

    // Winner search: first valid index in order base, base+1, ... (mod 4)
    always_comb begin : search
        logic [SEL_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = SEL_W'(base + SEL_W'(i));
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Data steering: only the winner's payload passes
    always_comb begin
        mux_data = '0;
        case (winner)
            2'd0:    mux_data = req_data0;
            2'd1:    mux_data = req_data1;
            2'd2:    mux_data = req_data2;
            default: mux_data = req_data3;
        endcase
    end

    // Combinational one-hot grant, suppressed during reset
    always_comb begin
        req_ready = '0;
        if (!rst && load) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Output stage: load winner, drain to empty when idle, hold on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (can_load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= winner;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (both arbitration builds).
module tb_mux4_rr_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] req_data2;
    logic [WIDTH-1:0] req_data3;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int tests;
    int fails;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX4_RR_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Advance one edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse leaving inputs idle
    task automatic do_reset();
        req_valid = '0;
        out_ready = 1'b0;
        req_data0 = '0;
        req_data1 = '0;
        req_data2 = '0;
        req_data3 = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 4'd0 || out_sel !== 2'd0) begin
            fails++; $display("FAIL reset_state got v=%b d=%h s=%0d want v=0 d=0 s=0",
                              out_valid, out_data, out_sel);
        end
        do_reset();
    endtask

    // All four valid, consumer always ready: round-robin sweep, no bubbles
    task automatic test_all_valid();
        logic [3:0] exp_d [5];
        logic [1:0] exp_s [5];
        logic [3:0] exp_r;
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        do_reset();
        req_data0 = 4'hA; req_data1 = 4'hB; req_data2 = 4'hC; req_data3 = 4'hD;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!RR) begin exp_s[k] = 2'd0; exp_d[k] = 4'hA; end
            exp_r = 4'b0001 << exp_s[k];
            #1;
            tests++;
            if (req_ready !== exp_r) begin
                fails++; $display("FAIL all_valid_grant[%0d] got %b want %b", k, req_ready, exp_r);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_sel !== exp_s[k]) begin
                fails++; $display("FAIL all_valid_out[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                                  k, out_valid, out_data, out_sel, exp_d[k], exp_s[k]);
            end
        end
    endtask

    // Stall with a held item, then release
    task automatic test_stall();
        do_reset();
        req_data0 = 4'h5; req_data1 = 4'h6; req_data2 = 4'h7; req_data3 = 4'h8;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd0) begin
            fails++; $display("FAIL stall_first got v=%b d=%h s=%0d want v=1 d=5 s=0",
                              out_valid, out_data, out_sel);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (req_ready !== 4'b0000) begin
                fails++; $display("FAIL stall_grant[%0d] got %b want 0000", k, req_ready);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd0) begin
                fails++; $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d want v=1 d=5 s=0",
                                  k, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== (RR ? 4'b0010 : 4'b0001)) begin
            fails++; $display("FAIL stall_release_grant got %b want %b",
                              req_ready, (RR ? 4'b0010 : 4'b0001));
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== (RR ? 4'h6 : 4'h5) || out_sel !== (RR ? 2'd1 : 2'd0)) begin
            fails++; $display("FAIL stall_release_out got d=%h s=%0d want d=%h s=%0d",
                              out_data, out_sel, (RR ? 4'h6 : 4'h5), (RR ? 2'd1 : 2'd0));
        end
    endtask

    // Pointer wrap: winner 1, then 1001 must go 3 then 0
    task automatic test_rr_wrap();
        do_reset();
        req_data0 = 4'h9; req_data1 = 4'h1; req_data3 = 4'hC;
        out_ready = 1'b1;
        req_valid = 4'b0010;
        step();
        tests++;
        if (out_sel !== 2'd1 || out_data !== 4'h1) begin
            fails++; $display("FAIL wrap_first got s=%0d d=%h want s=1 d=1", out_sel, out_data);
        end
        req_valid = 4'b1001;
        step();
        tests++;
        if (out_sel !== (RR ? 2'd3 : 2'd0) || out_data !== (RR ? 4'hC : 4'h9)) begin
            fails++; $display("FAIL wrap_second got s=%0d d=%h want s=%0d d=%h",
                              out_sel, out_data, (RR ? 2'd3 : 2'd0), (RR ? 4'hC : 4'h9));
        end
        step();
        tests++;
        if (out_sel !== 2'd0 || out_data !== 4'h9) begin
            fails++; $display("FAIL wrap_third got s=%0d d=%h want s=0 d=9", out_sel, out_data);
        end
    endtask

    // No requests while held item drains: valid drops, payload holds
    task automatic test_idle();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL idle_grant got %b want 0000", req_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 4'h9 || out_sel !== 2'd0) begin
            fails++; $display("FAIL idle_out got v=%b d=%h s=%0d want v=0 d=9 s=0",
                              out_valid, out_data, out_sel);
        end
    endtask

    // Unselected X payload must never appear on the output
    task automatic test_x_data();
        logic [3:0] exp_d [3];
        exp_d = RR ? '{4'd7, 4'd10, 4'd3} : '{4'd7, 4'd7, 4'd7};
        do_reset();
        req_data0 = 4'd7; req_data1 = 4'd10; req_data2 = 4'd3; req_data3 = 'x;
        req_valid = 4'b0111;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (out_data !== exp_d[k] || out_valid !== 1'b1) begin
                fails++; $display("FAIL x_data[%0d] got v=%b d=%h want v=1 d=%h",
                                  k, out_valid, out_data, exp_d[k]);
            end
        end
        req_data3 = '0;
    endtask

    // Async reset mid-stream clears everything before the next edge
    task automatic test_reset_midstream();
        do_reset();
        req_data0 = 4'h1; req_data1 = 4'h2; req_data2 = 4'h3; req_data3 = 4'h4;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0 || req_ready !== 4'b0000) begin
            fails++; $display("FAIL midreset_clear got v=%b d=%h s=%0d r=%b want 0 0 0 0000",
                              out_valid, out_data, out_sel, req_ready);
        end
        #1;
        rst = 1'b0;
        req_valid = 4'b0110;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL midreset_grant got %b want 0010", req_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h2) begin
            fails++; $display("FAIL midreset_first got v=%b s=%0d d=%h want v=1 s=1 d=2",
                              out_valid, out_sel, out_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        req_data0 = '0; req_data1 = '0; req_data2 = '0; req_data3 = '0;
        #2;
        test_reset();
        test_all_valid();
        test_stall();
        test_rr_wrap();
        test_idle();
        test_x_data();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer among four valid/ready requesters and drives a single registered output stage. Each cycle it picks one requester, steers that requester's data through the mux and captures the result in an output register that a downstream consumer drains under valid/ready flow control. It sits between four independent producers and one shared consumer.

## Interface

- `WIDTH`, default 4, data width of every requester and of the output.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `req_valid`  input  4  bit i set: requester i presents data.
- `req_data0` .. `req_data3`  input  WIDTH each  requester payloads.
- `req_ready`  output  4  bit i set: requester i's item is taken at this edge; one-hot or zero.
- `out_valid`  output  1  output register holds an item.
- `out_data`  output  WIDTH  payload of the held item.
- `out_sel`  output  2  index of the requester that supplied the held item.
- `out_ready`  input  1  consumer takes the held item at this edge.

## Operation

- `can_load = !out_valid || out_ready`.
- Winner search runs only when `can_load` is high. Round-robin search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The winner is the first index with `req_valid` set.
- `req_ready` is combinational. It is one-hot on the winner. It is all zero when `can_load` is low or no request is valid.
- Load at the edge when `can_load` and the winner exists: `out_data <= mux(winner)`, `out_sel <= winner`, `out_valid <= 1`, `ptr <= winner + 1` mod 4, so 3 wraps to 0.
- If `can_load` is high and no request is valid: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` hold.
- If `can_load` is low: all registers hold.
- Requesters hold `req_valid` and data stable until their `req_ready` bit is seen. The block does not check this.
- Data from non-selected requesters, including X, never reaches `out_data`.
- Reset state: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - Reset is applied asynchronously.
  - Reset mid-transfer drops the held item.
  - `req_ready` is all zero while `rst` is high.

## Timing

- Latency is 1 cycle: an item accepted at edge N is visible on `out_data` after edge N.
- Throughput is 1 item per cycle while `out_ready` is high and any request is valid.
- If `out_ready` and a new request are both present in the same cycle, the held item is consumed and replaced at the same edge, with no bubble.
- While `out_valid=1` and `out_ready=0`, `out_valid`, `out_data` and `out_sel` are stable.
- `ptr` advances only on a load. It does not advance on idle or stall cycles.
- The first grant after reset goes to the lowest valid index, because `ptr`=0.

## Configuration

- Controlled by the macro `MUX4_RR_ARBITER_ROUND_ROBIN_EN`.
- With the macro defined: round-robin selection as described in Operation.
- Without the macro: fixed priority, with requester 0 highest and requester 3 lowest.
  - `ptr` is removed.
  - All handshake, latency and reset rules are unchanged.

## Test plan

- All four requests valid with data a, b, c, d, and `out_ready`=1 throughout. Required with the macro: outputs a, b, c, d, a on successive cycles with `out_sel` 0, 1, 2, 3, 0. Required without the macro: a every cycle with `out_sel`=0.
- First item loaded, then `out_ready`=0 for 3 cycles. Required: `out_valid`=1 with `out_data`/`out_sel` frozen, and `req_ready`=0000. Then `out_ready`=1. Required: the next winner loads at that edge.
- Grant requester 1 (so `ptr`=2), then only `req_valid`=1001. Required with the macro: grant 3, then grant 0.
- `req_valid`=0000 with `out_valid`=1 and `out_ready`=1. Required: `out_valid`=0 after the edge and `out_data` unchanged.
- `req_data3`=X, `req_valid`=0111, with data 7, 10, 3. Required: outputs 7, 10, 3 with no X on `out_data`.
- Assert `rst` mid-stream while `out_valid`=1. Required: `out_valid`, `out_data`, `out_sel` and `ptr` go to 0 before the next edge. After release, the first grant goes to the lowest valid index.
